rf_write_ctrl: RTL and testbench
================================

Name: rf_write_ctrl

Overview:
- Write-port controller directly upstream of the 32-bit register cells in the register file.
- Accepts write requests over a valid/ready handshake and buffers them in a small in-order FIFO.
- Commits one write per cycle as registered drive signals: data bus, global write strobe, one-hot register select and per-bit write mask.
- These outputs feed the cells' data, global-enable and per-bit enable inputs directly.

Parameters:
- WD, 32, data width in bits; must be a multiple of 8.
- NREG, 32, number of registers.
- AW, 5, address width; clog2(NREG).
- DEPTH, 4, write FIFO depth; power of two, at least 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_valid  input  1  write request valid.
- wr_ready  output  1  controller can accept a request this cycle.
- wr_addr  input  AW  target register index.
- wr_data  input  WD  write data.
- wr_bmask  input  WD/8  byte enables; bit i covers data bits 8i..8i+7.
- rf_stall  input  1  downstream hold; no commit while high.
- rf_we  output  1  global write strobe to the register cells.
- rf_sel  output  NREG  one-hot register select.
- rf_mask  output  WD  per-bit write enable.
- rf_data  output  WD  write data to the register cells.
- pending  output  clog2(DEPTH)+1  number of FIFO entries.

Behaviour:
- Reset (synchronous, active-high):
  - Clears FIFO pointers and count; all queued writes are discarded.
  - rf_we=0, rf_sel=0, rf_mask=0, rf_data=0, pending=0.
  - wr_ready=0 during the reset cycle.
  - Reset asserted mid-stream loses all queued writes; no commit occurs on the reset edge.
- Handshake:
  - wr_ready = (pending != DEPTH) && !reset.
  - A request is accepted on an edge where wr_valid && wr_ready.
  - wr_addr, wr_data and wr_bmask are captured at that edge.
  - When full, wr_ready=0, even if a pop happens on the same edge (no full pass-through).
- Commit (every edge, not in reset):
  - If !rf_stall and the FIFO held at least one entry before the edge, the head is popped and the output registers load from it.
  - Otherwise rf_we, rf_sel and rf_mask load 0; rf_data holds its value.
- Latency:
  - A request accepted at edge k appears on rf_* after edge k+1 at the earliest, i.e. 2 edges from presentation.
  - There is no same-edge bypass; the pop only sees entries present before the edge.
- Popped-entry decode:
  - rf_sel = one-hot(addr).
  - rf_mask = each bmask bit replicated ×8.
  - rf_data = data.
  - rf_we = 1.
- Drop rule: an entry with addr==0 (hardwired zero register), bmask==0, or addr>=NREG is popped with rf_we=0, rf_sel=0, rf_mask=0.
- Simultaneous push and pop:
  - Allowed when not full; pending is unchanged.
  - Order is strictly FIFO.
- Pointers wrap modulo DEPTH; pending ranges 0..DEPTH.
- Sequential state: FIFO storage, read/write pointers, count, output registers.

Optional Feature:
- Macro: RF_WRITE_CTRL_STATS_EN.
- When defined, adds two outputs:
  - commit_cnt [15:0]: increments on each rf_we=1 commit.
  - drop_cnt [15:0]: increments on each dropped pop.
- Both counters wrap at 16'hFFFF→0 and clear on reset.
- When undefined, these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Single write: addr=5, data=32'hDEADBEEF, bmask=4'hF at edge k → after edge k+1: rf_we=1, rf_sel=32'h20, rf_mask=32'hFFFFFFFF, rf_data=32'hDEADBEEF; after edge k+2: rf_we=0, pending=0.
- Byte mask: addr=3, bmask=4'b0101 → rf_mask=32'h00FF00FF, rf_sel=32'h8.
- Fill/backpressure: rf_stall=1, push 4 writes → pending=4, wr_ready=0, fifth request not accepted. Release stall → 4 consecutive rf_we=1 commits in push order, then wr_ready=1.
- Drop: addr=0 write, then addr=7 with bmask=0 → both popped with rf_we=0 and rf_sel=0. With stats enabled: drop_cnt=2, commit_cnt=0.
- Streaming: wr_valid=1 every cycle for 10 cycles with rf_stall=0 → pending stays ≤1, 10 commits in order, no gaps after the first.
- Reset mid-operation: 3 entries queued with stall high, assert reset one cycle → pending=0, all rf_* =0, no commit after stall release.

Source files
------------

// File: rtl/rf_write_ctrl.sv
// Register-file write-port controller: in-order write FIFO feeding registered cell drives.
// Optional commit/drop statistics counters are built when RF_WRITE_CTRL_STATS_EN is defined.
module rf_write_ctrl #(
  parameter int WD    = 32,
  parameter int NREG  = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [AW-1:0]            wr_addr,
  input  logic [WD-1:0]            wr_data,
  input  logic [WD/8-1:0]          wr_bmask,
  input  logic                     rf_stall,
  output logic                     rf_we,
  output logic [NREG-1:0]          rf_sel,
  output logic [WD-1:0]            rf_mask,
  output logic [WD-1:0]            rf_data,
  output logic [$clog2(DEPTH):0]   pending
`ifdef RF_WRITE_CTRL_STATS_EN
  ,
  output logic [15:0]              commit_cnt,
  output logic [15:0]              drop_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int NB = WD / 8;
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [WD-1:0] data;
    logic [NB-1:0] bmask;
  } req_t;

  req_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          push, pop, keep;
  req_t          head;
  logic [NREG-1:0] sel_d;
  logic [WD-1:0]   mask_d;

  // Full blocks acceptance even when a pop lands on the same edge.
  assign wr_ready = (count != FULL) && !reset;
  assign push     = wr_valid && wr_ready;
  assign pop      = !reset && !rf_stall && (count != '0);
  assign pending  = count;
  assign head     = mem[rd_ptr];

  // Zero register, empty byte mask and out-of-range index retire silently.
  assign keep  = (head.addr != '0) && (head.bmask != '0) &&
                 ({1'b0, head.addr} < (AW+1)'(NREG));
  assign sel_d = keep ? (NREG'(1) << head.addr) : '0;

  for (genvar b = 0; b < NB; b++) begin : g_mask
    assign mask_d[8*b +: 8] = {8{head.bmask[b] & keep}};
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{addr: wr_addr, data: wr_data, bmask: wr_bmask};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we   <= 1'b0;
      rf_sel  <= '0;
      rf_mask <= '0;
      rf_data <= '0;
    end else if (pop) begin
      rf_we   <= keep;
      rf_sel  <= sel_d;
      rf_mask <= mask_d;
      rf_data <= head.data;
    end else begin
      rf_we   <= 1'b0;
      rf_sel  <= '0;
      rf_mask <= '0;
    end
  end

`ifdef RF_WRITE_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      commit_cnt <= '0;
      drop_cnt   <= '0;
    end else if (pop) begin
      if (keep) commit_cnt <= commit_cnt + 1'b1;
      else      drop_cnt   <= drop_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rf_write_ctrl.sv
// Self-checking bench for rf_write_ctrl: randomized traffic against a queue-based model.
module tb_rf_write_ctrl;
  localparam int DEPTH = 4;
  localparam int NREG  = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_bmask;
  logic        rf_stall;
  logic        rf_we;
  logic [31:0] rf_sel;
  logic [31:0] rf_mask;
  logic [31:0] rf_data;
  logic [2:0]  pending;
`ifdef RF_WRITE_CTRL_STATS_EN
  logic [15:0] commit_cnt, drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  rf_write_ctrl #(.WD(32), .NREG(NREG), .AW(5), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_bmask(wr_bmask),
    .rf_stall(rf_stall), .rf_we(rf_we), .rf_sel(rf_sel), .rf_mask(rf_mask),
    .rf_data(rf_data), .pending(pending)
`ifdef RF_WRITE_CTRL_STATS_EN
    , .commit_cnt(commit_cnt), .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of requests, committed in order.
  typedef struct { logic [4:0] a; logic [31:0] d; logic [3:0] b; } req_s;
  req_s        mq[$];
  req_s        h;
  logic        m_we;
  logic [31:0] m_sel, m_mask, m_data;
  logic [15:0] m_commit, m_drop;
  bit          acc, pp, kp;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_we = 1'b0; m_sel = '0; m_mask = '0; m_data = '0;
      m_commit = '0; m_drop = '0;
    end else begin
      acc = wr_valid && (mq.size() < DEPTH);
      pp  = !rf_stall && (mq.size() > 0);
      if (pp) begin
        h  = mq.pop_front();
        kp = (h.a != 0) && (h.b != 0) && (int'(h.a) < NREG);
        m_we   = kp;
        m_sel  = kp ? (32'd1 << h.a) : '0;
        for (int i = 0; i < 4; i++) m_mask[8*i +: 8] = (kp && h.b[i]) ? 8'hFF : 8'h00;
        m_data = h.d;
        if (kp) m_commit = m_commit + 16'd1;
        else    m_drop   = m_drop + 16'd1;
      end else begin
        m_we = 1'b0; m_sel = '0; m_mask = '0;
      end
      if (acc) mq.push_back('{wr_addr, wr_data, wr_bmask});
    end
  end

  function automatic logic [100:0] exp_vec();
    logic m_ready;
    m_ready = (mq.size() != DEPTH) && !reset;
    return {m_we, m_sel, m_mask, m_data, 3'(mq.size()), m_ready};
  endfunction

  wire [100:0] act_vec = {rf_we, rf_sel, rf_mask, rf_data, pending, wr_ready};

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
    wr_valid = v; wr_addr = a; wr_data = d; wr_bmask = b;
  endtask

  task automatic test_reset();
    reset = 1'b1; rf_stall = 1'b0;
    drive(1'b1, 5'd9, 32'h1234_5678, 4'hF);
    tick(); tick();
    checks++;
    if ({rf_we, rf_sel, rf_mask, rf_data, pending, wr_ready} !== 101'd0) begin
      errors++; $display("FAIL reset_state: got %h exp 0", act_vec);
    end
    drive(1'b0, '0, '0, '0);
    reset = 1'b0;
    #1;
    checks++;
    if (wr_ready !== 1'b1 || pending !== 3'd0) begin
      errors++; $display("FAIL reset_release: ready=%b pending=%0d exp ready=1 pending=0", wr_ready, pending);
    end
  endtask

  task automatic test_single();
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 4'hF);
    tick();
    drive(1'b0, '0, '0, '0);
    checks++;
    if (rf_we !== 1'b0 || pending !== 3'd1) begin
      errors++; $display("FAIL single_no_bypass: we=%b pending=%0d exp we=0 pending=1", rf_we, pending);
    end
    tick();
    checks++;
    if ({rf_we, rf_sel, rf_mask, rf_data} !== {1'b1, 32'h20, 32'hFFFF_FFFF, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL single_commit: we=%b sel=%h mask=%h data=%h", rf_we, rf_sel, rf_mask, rf_data);
    end
    tick();
    checks++;
    if (rf_we !== 1'b0 || pending !== 3'd0 || rf_sel !== 32'h0) begin
      errors++; $display("FAIL single_idle: we=%b sel=%h pending=%0d exp 0", rf_we, rf_sel, pending);
    end
  endtask

  task automatic test_bytemask();
    drive(1'b1, 5'd3, 32'hCAFE_F00D, 4'b0101);
    tick();
    drive(1'b0, '0, '0, '0);
    tick();
    checks++;
    if ({rf_we, rf_sel, rf_mask} !== {1'b1, 32'h8, 32'h00FF_00FF}) begin
      errors++; $display("FAIL bytemask: we=%b sel=%h mask=%h exp 1/8/00ff00ff", rf_we, rf_sel, rf_mask);
    end
    tick();
  endtask

  task automatic test_fill();
    logic [31:0] dq[$];
    logic [31:0] d;
    rf_stall = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      d = $urandom;
      dq.push_back(d);
      drive(1'b1, 5'($urandom_range(1, 31)), d, 4'($urandom_range(1, 15)));
      tick();
    end
    drive(1'b1, 5'd1, 32'hBAD0_0BAD, 4'hF);
    checks++;
    if (pending !== 3'd4 || wr_ready !== 1'b0) begin
      errors++; $display("FAIL fill_full: pending=%0d ready=%b exp 4/0", pending, wr_ready);
    end
    tick();
    checks++;
    if (pending !== 3'd4) begin
      errors++; $display("FAIL fill_fifth: pending=%0d exp 4", pending);
    end
    // Release the stall while still offering a request: still refused since full.
    rf_stall = 1'b0;
    #1;
    checks++;
    if (wr_ready !== 1'b0) begin
      errors++; $display("FAIL fill_no_passthru: ready=%b exp 0", wr_ready);
    end
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      drive(1'b0, '0, '0, '0);
      checks++;
      if (rf_we !== 1'b1 || rf_data !== dq[i] || act_vec !== exp_vec()) begin
        errors++; $display("FAIL fill_drain%0d: we=%b data=%h exp we=1 data=%h", i, rf_we, rf_data, dq[i]);
      end
    end
    checks++;
    if (wr_ready !== 1'b1 || pending !== 3'd0) begin
      errors++; $display("FAIL fill_ready_back: ready=%b pending=%0d exp 1/0", wr_ready, pending);
    end
    tick();
  endtask

  task automatic test_drop();
    reset = 1'b1; tick(); reset = 1'b0;
    drive(1'b1, 5'd0, 32'h1111_1111, 4'hF);
    tick();
    drive(1'b1, 5'd7, 32'h2222_2222, 4'h0);
    tick();
    drive(1'b0, '0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rf_we !== 1'b0 || rf_sel !== 32'h0 || rf_mask !== 32'h0) begin
        errors++; $display("FAIL drop%0d: we=%b sel=%h mask=%h exp 0", i, rf_we, rf_sel, rf_mask);
      end
      tick();
    end
`ifdef RF_WRITE_CTRL_STATS_EN
    checks++;
    if (drop_cnt !== 16'd2 || commit_cnt !== 16'd0) begin
      errors++; $display("FAIL drop_stats: drop=%0d commit=%0d exp 2/0", drop_cnt, commit_cnt);
    end
`endif
    checks++;
    if (pending !== 3'd0) begin
      errors++; $display("FAIL drop_pending: pending=%0d exp 0", pending);
    end
  endtask

  task automatic test_stream();
    int  commits = 0;
    bit  seen = 0, gap = 0;
    rf_stall = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i < 10) drive(1'b1, 5'($urandom_range(1, 31)), $urandom, 4'($urandom_range(1, 15)));
      else        drive(1'b0, '0, '0, '0);
      tick();
      if (rf_we) begin seen = 1; commits++; end
      else if (seen && commits < 10) gap = 1;
      checks++;
      if (pending > 3'd1 || act_vec !== exp_vec()) begin
        errors++; $display("FAIL stream_cyc%0d: got %h exp %h", i, act_vec, exp_vec());
      end
    end
    checks++;
    if (commits != 10 || gap) begin
      errors++; $display("FAIL stream_count: commits=%0d gap=%0d exp 10/0", commits, gap);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom), $urandom, 4'($urandom));
      rf_stall = ($urandom_range(0, 3) == 0);
      reset    = ($urandom_range(0, 60) == 0);
      tick();
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++; $display("FAIL random_cyc%0d: got %h exp %h", i, act_vec, exp_vec());
      end
`ifdef RF_WRITE_CTRL_STATS_EN
      checks++;
      if (commit_cnt !== m_commit || drop_cnt !== m_drop) begin
        errors++; $display("FAIL random_stats%0d: commit=%0d drop=%0d exp %0d/%0d", i, commit_cnt, drop_cnt, m_commit, m_drop);
      end
`endif
    end
    reset = 1'b0; rf_stall = 1'b0; drive(1'b0, '0, '0, '0);
    tick(); tick(); tick(); tick(); tick();
  endtask

  task automatic test_reset_mid();
    rf_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(i + 4), $urandom, 4'hF);
      tick();
    end
    drive(1'b0, '0, '0, '0);
    checks++;
    if (pending !== 3'd3) begin
      errors++; $display("FAIL mid_queued: pending=%0d exp 3", pending);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({rf_we, rf_sel, rf_mask, rf_data, pending} !== 100'd0) begin
      errors++; $display("FAIL mid_reset: got %h exp 0", act_vec);
    end
    rf_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (rf_we !== 1'b0 || pending !== 3'd0) begin
        errors++; $display("FAIL mid_after%0d: we=%b pending=%0d exp 0/0", i, rf_we, pending);
      end
    end
  endtask

  initial begin
    reset = 1'b1; rf_stall = 1'b0;
    drive(1'b0, '0, '0, '0);
    test_reset();
    test_single();
    test_bytemask();
    test_fill();
    test_drop();
    test_stream();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
